// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: serialises 8-bit stereo PCM pairs into an I2S-style ws/sd stream.
// One bit per clk, MSB first, one-bit delay after each ws edge, zero padded.
// A single holding register decouples the producer from the frame cadence.
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int SLOT_CYCLES    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUMBER_OF_BITS-1:0] pcm_left,
  input  logic [NUMBER_OF_BITS-1:0] pcm_right,
  input  logic                      pcm_valid,
  output logic                      pcm_ready,
  output logic                      ws,
  output logic                      sd,
  output logic                      frame_start,
  output logic                      underrun
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MSB_CYC  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LSB_CYC  = CNT_W'(NUMBER_OF_BITS);

  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic                      ws_nxt;
  logic                      slot_end;
  logic                      load;
  logic                      accept;
  logic                      sd_nxt;
  logic [NUMBER_OF_BITS-1:0] hold_l;
  logic [NUMBER_OF_BITS-1:0] hold_r;
  logic [NUMBER_OF_BITS-1:0] tx_l;
  logic [NUMBER_OF_BITS-1:0] tx_r;
  logic [NUMBER_OF_BITS-1:0] slot_sample;

  // Bit of the sample that belongs on sd in slot cycle k (k=1 carries the MSB).
  function automatic logic slot_bit(input logic [NUMBER_OF_BITS-1:0] sample,
                                    input logic [CNT_W-1:0]          k);
    logic [NUMBER_OF_BITS-1:0] shifted;
    shifted = sample >> (LSB_CYC - k);
    return shifted[0];
  endfunction

  // Next slot position, load-point detection and the serial bit for the next cycle.
  always_comb begin
    slot_end    = (cnt == LAST_CYC);
    cnt_nxt     = slot_end ? '0 : cnt + 1'b1;
    ws_nxt      = ws ^ slot_end;
    load        = slot_end && ws;
    accept      = pcm_valid && pcm_ready;
    slot_sample = ws_nxt ? tx_r : tx_l;
    sd_nxt      = 1'b0;
    if (cnt_nxt >= MSB_CYC && cnt_nxt <= LSB_CYC) begin
      sd_nxt = slot_bit(slot_sample, cnt_nxt);
    end
  end

  // Slot counter, word select, serial data and frame pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      ws          <= 1'b0;
      sd          <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      ws          <= ws_nxt;
      sd          <= sd_nxt;
      frame_start <= load;
      underrun    <= load && pcm_ready;
    end
  end

  // Holding-register occupancy; an accept on the load edge is kept for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcm_ready <= 1'b1;
    end else if (accept) begin
      pcm_ready <= 1'b0;
    end else if (load) begin
      pcm_ready <= 1'b1;
    end
  end

  // Holding-register data, captured only at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_l <= pcm_left;
      hold_r <= pcm_right;
    end
  end

  // Transmit registers: held pair at the load point, or silence if nothing is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_l <= '0;
      tx_r <= '0;
    end else if (load) begin
      tx_l <= pcm_ready ? '0 : hold_l;
      tx_r <= pcm_ready ? '0 : hold_r;
    end
  end

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Testbench for pcm_to_i2s: frame-level reference model plus directed scenarios.
module tb_pcm_to_i2s;

  localparam int NB    = 8;
  localparam int SLOT  = 32;
  localparam int FRAME = 2 * SLOT;
  localparam int MAXF  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] pcm_left = '0;
  logic [NB-1:0] pcm_right = '0;
  logic          pcm_valid = 1'b0;
  logic          pcm_ready;
  logic          ws;
  logic          sd;
  logic          frame_start;
  logic          underrun;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycle index since reset and per-frame content.
  int            m_n;
  logic          m_held;
  logic [NB-1:0] m_hl, m_hr;
  logic [NB-1:0] m_fl [MAXF];
  logic [NB-1:0] m_fr [MAXF];
  logic          m_fu [MAXF];
  int            acc  [MAXF];

  // Observed DUT stream, deserialised per frame.
  logic [NB-1:0] rxl [MAXF];
  logic [NB-1:0] rxr [MAXF];
  int            ru  [MAXF];

  pcm_to_i2s #(.NUMBER_OF_BITS(NB), .SLOT_CYCLES(SLOT)) dut (
    .clk         (clk),
    .reset       (reset),
    .pcm_left    (pcm_left),
    .pcm_right   (pcm_right),
    .pcm_valid   (pcm_valid),
    .pcm_ready   (pcm_ready),
    .ws          (ws),
    .sd          (sd),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: each frame carries whatever pair was held when it began.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n    = 0;
      m_held = 1'b0;
      m_hl   = '0;
      m_hr   = '0;
      for (int i = 0; i < MAXF; i++) begin
        m_fl[i] = '0;
        m_fr[i] = '0;
        m_fu[i] = 1'b0;
        acc[i]  = 0;
      end
    end else begin
      logic was_empty;
      int   f;
      was_empty = !m_held;
      if (pcm_valid && pcm_ready && ((m_n + 1) / FRAME) < MAXF) acc[(m_n + 1) / FRAME]++;
      m_n++;
      f = m_n / FRAME;
      if ((m_n % FRAME) == 0 && f < MAXF) begin
        m_fl[f] = m_held ? m_hl : '0;
        m_fr[f] = m_held ? m_hr : '0;
        m_fu[f] = !m_held;
        m_held  = 1'b0;
      end
      if (pcm_valid && was_empty) begin
        m_held = 1'b1;
        m_hl   = pcm_left;
        m_hr   = pcm_right;
      end
    end
  end

  // Per-cycle compare against the model, plus capture of the serial stream.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAXF; i++) begin
        rxl[i] = '0;
        rxr[i] = '0;
        ru[i]  = 0;
      end
    end else begin
      int            k, f;
      logic          ews, esd, efs, eun;
      logic [NB-1:0] samp, sh;
      k   = m_n % SLOT;
      ews = ((m_n / SLOT) % 2) == 1;
      f   = m_n / FRAME;
      if (f < MAXF) begin
        samp = ews ? m_fr[f] : m_fl[f];
        esd  = 1'b0;
        if (k >= 1 && k <= NB) begin
          sh  = samp >> (NB - k);
          esd = sh[0];
        end
        efs = (k == 0) && !ews && (f > 0);
        eun = efs && m_fu[f];
        check("ws", 32'(ws), 32'(ews));
        check("sd", 32'(sd), 32'(esd));
        check("frame_start", 32'(frame_start), 32'(efs));
        check("underrun", 32'(underrun), 32'(eun));
        check("pcm_ready", 32'(pcm_ready), 32'(!m_held));
        if (k >= 1 && k <= NB) begin
          if (!ews) rxl[f] = {rxl[f][NB-2:0], sd};
          else      rxr[f] = {rxr[f][NB-2:0], sd};
        end
        if (underrun) ru[f]++;
      end
    end
  end

  // Hold reset for a few cycles and release it just after a falling edge (cycle 0).
  task automatic reset_dut();
    reset     = 1'b1;
    pcm_valid = 1'b0;
    pcm_left  = '0;
    pcm_right = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int   i;
    logic rdy;

    // Single pair plus ws/frame cadence.
    reset_dut();
    pcm_valid = 1'b1; pcm_left = 8'hA5; pcm_right = 8'h3C;
    @(negedge clk);
    pcm_valid = 1'b0;
    check("ready_after_accept", 32'(pcm_ready), 32'd0);
    repeat (30) @(negedge clk);
    check("ws_cycle31", 32'(ws), 32'd0);
    @(negedge clk);
    check("ws_cycle32", 32'(ws), 32'd1);
    repeat (32) @(negedge clk);
    check("fs_cycle64", 32'(frame_start), 32'd1);
    check("un_cycle64", 32'(underrun), 32'd0);
    check("ready_cycle64", 32'(pcm_ready), 32'd1);
    @(negedge clk);
    check("msb_cycle65", 32'(sd), 32'd1);
    repeat (63) @(negedge clk);
    check("fs_cycle128", 32'(frame_start), 32'd1);
    check("un_cycle128", 32'(underrun), 32'd1);
    repeat (72) @(negedge clk);
    check("single_left", 32'(rxl[1]), 32'h A5);
    check("single_right", 32'(rxr[1]), 32'h3C);
    check("single_un_f0", 32'(ru[0]), 32'd0);
    check("single_un_f1", 32'(ru[1]), 32'd0);
    check("single_f2_silent", 32'(rxl[2]), 32'd0);

    // Underrun after the last pair 11/22.
    reset_dut();
    pcm_valid = 1'b1; pcm_left = 8'h11; pcm_right = 8'h22;
    @(negedge clk);
    pcm_valid = 1'b0;
    repeat (139) @(negedge clk);
    check("ur_left", 32'(rxl[1]), 32'h11);
    check("ur_right", 32'(rxr[1]), 32'h22);
    check("ur_un_f1", 32'(ru[1]), 32'd0);
    check("ur_f2_left", 32'(rxl[2]), 32'd0);
    check("ur_f2_right", 32'(rxr[2]), 32'd0);
    check("ur_un_f2", 32'(ru[2]), 32'd1);

    // Backpressure: valid held high, pair advances after each accept.
    reset_dut();
    i = 0;
    pcm_valid = 1'b1; pcm_left = 8'h10; pcm_right = 8'h90;
    repeat (6 * FRAME) begin
      rdy = pcm_ready;
      @(negedge clk);
      if (rdy) begin
        i++;
        pcm_left  = 8'(8'h10 + i);
        pcm_right = 8'(8'h90 + i);
      end
    end
    pcm_valid = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      check("bp_left", 32'(rxl[f]), 32'(8'h10 + f - 1));
      check("bp_right", 32'(rxr[f]), 32'(8'h90 + f - 1));
      check("bp_underrun", 32'(ru[f]), 32'd0);
    end
    for (int f = 0; f <= 5; f++) check("bp_accepts", 32'(acc[f]), 32'd1);

    // Accept exactly on the load edge with an empty holding register.
    reset_dut();
    repeat (63) @(negedge clk);
    pcm_valid = 1'b1; pcm_left = 8'h5A; pcm_right = 8'hC3;
    @(negedge clk);
    pcm_valid = 1'b0;
    check("le_ready", 32'(pcm_ready), 32'd0);
    check("le_underrun", 32'(underrun), 32'd1);
    repeat (140) @(negedge clk);
    check("le_un_f1", 32'(ru[1]), 32'd1);
    check("le_f1_left", 32'(rxl[1]), 32'd0);
    check("le_f2_left", 32'(rxl[2]), 32'h5A);
    check("le_f2_right", 32'(rxr[2]), 32'hC3);
    check("le_un_f2", 32'(ru[2]), 32'd0);

    // Mid-frame reset while FF/FF is on the wire and 77/88 is held.
    reset_dut();
    pcm_valid = 1'b1; pcm_left = 8'hFF; pcm_right = 8'hFF;
    @(negedge clk);
    pcm_valid = 1'b0;
    repeat (63) @(negedge clk);
    pcm_valid = 1'b1; pcm_left = 8'h77; pcm_right = 8'h88;
    @(negedge clk);
    pcm_valid = 1'b0;
    check("mr_held", 32'(pcm_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("mr_sd_before", 32'(sd), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mr_ws_async", 32'(ws), 32'd0);
    check("mr_sd_async", 32'(sd), 32'd0);
    check("mr_ready_async", 32'(pcm_ready), 32'd1);
    check("mr_fs_async", 32'(frame_start), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (140) @(negedge clk);
    check("mr_un_f0", 32'(ru[0]), 32'd0);
    check("mr_un_f1", 32'(ru[1]), 32'd1);
    check("mr_f1_left", 32'(rxl[1]), 32'd0);
    check("mr_f1_right", 32'(rxr[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
